iob2axi_rd_stream: RTL

IOB2AXI_RD_STREAM -- requirements
Module: iob2axi_rd_stream

---
 rtl/iob2axi_rd_stream.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/iob2axi_rd_stream.sv
// rtl/iob2axi_rd_stream.sv - AXI4 burst reader feeding a native pop-on-request read stream
//
// Purpose: on run, reads `length` words from `addr` with AXI4 read bursts and
// stores them in an internal FIFO that the native side drains one word per
// request.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   run, addr, length          transfer start pulse, start byte address, word count
//   ready, error               idle flag, sticky bus error (cleared by accepted run)
//   s_valid, s_rdata, s_ready  native pop request, data, one-cycle acknowledge
//   m_ar*, m_r*                AXI4 read address / read data channels
// Macro IOB2AXI_RD_STREAM_4K_SPLIT_EN: when defined, bursts never cross a 4 KB boundary.

module iob2axi_rd_stream #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int BURST_W     = 8,
  parameter int FIFO_ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   length,
  output logic               ready,
  output logic               error,
  input  logic               s_valid,
  output logic [DATA_W-1:0]  s_rdata,
  output logic               s_ready,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic [BURST_W-1:0] m_arlen,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int DEPTH      = 1 << FIFO_ADDR_W;
  // Wide enough for remaining words, burst cap, 4 KB distance and FIFO depth.
  localparam int CW         = LEN_W + BURST_W + FIFO_ADDR_W + 14;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [BURST_W:0]     beats_q, beats_d;
  logic [BURST_W:0]     beat_cnt_q, beat_cnt_d;
  logic                 arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;
  logic [BURST_W-1:0]   arlen_q, arlen_d;
  logic                 error_q, error_d;
  logic [FIFO_ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_ADDR_W:0] level_q, level_d;
  logic                 s_ready_q, s_ready_d;
  logic [DATA_W-1:0]    s_rdata_q, s_rdata_d;

  logic [DATA_W-1:0]    mem [DEPTH];

  logic [CW-1:0]        rem_w, cap_w, beats_w, free_w;
  logic                 ar_fire, rbeat, is_last, push, pop, accept_run;

  // Size of the next burst, derived from the current address and remaining count.
  always_comb begin
    rem_w   = CW'(remaining_q);
    cap_w   = CW'(1) << BURST_W;
    beats_w = (rem_w < cap_w) ? rem_w : cap_w;
`ifdef IOB2AXI_RD_STREAM_4K_SPLIT_EN
    if (((CW'(4096) - CW'(addr_q[11:0])) >> BYTE_SHIFT) < beats_w) begin
      beats_w = (CW'(4096) - CW'(addr_q[11:0])) >> BYTE_SHIFT;
    end
`endif
    free_w  = CW'(DEPTH) - CW'(level_q);
  end

  assign accept_run = (state_q == IDLE) && run && (length != '0);
  assign ar_fire    = arvalid_q && m_arready;
  assign rbeat      = (state_q == DATA) && m_rvalid;
  // Burst end comes from our own beat count; m_rlast is only cross-checked.
  assign is_last    = (beat_cnt_q == beats_q - 1'b1);
  assign push       = rbeat;
  assign pop        = s_valid && (level_q != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_run) state_d = ADDR;
      ADDR: if (ar_fire) state_d = DATA;
      DATA: if (rbeat && is_last) begin
        state_d = (remaining_q == LEN_W'(beats_q)) ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready    = (state_q == IDLE);
    m_rready = (state_q == DATA);
  end

  // Datapath next values
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    error_d     = error_q;
    if (accept_run) begin
      addr_d      = addr;
      remaining_d = length;
      error_d     = 1'b0;
    end
    if (state_q == ADDR) begin
      // Only pops happen outside DATA, so free space never shrinks once granted.
      if (!arvalid_q && (free_w >= beats_w)) begin
        arvalid_d = 1'b1;
        araddr_d  = addr_q;
        arlen_d   = BURST_W'(beats_w - CW'(1));
        beats_d   = (BURST_W+1)'(beats_w);
      end
      if (ar_fire) begin
        arvalid_d  = 1'b0;
        beat_cnt_d = '0;
      end
    end
    if (rbeat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (m_rresp != 2'b00) error_d = 1'b1;
      if (m_rlast != is_last) error_d = 1'b1;
      if (is_last) begin
        addr_d      = addr_q + (ADDR_W'(beats_q) << BYTE_SHIFT);
        remaining_d = remaining_q - LEN_W'(beats_q);
        beat_cnt_d  = '0;
      end
    end
  end

  // FIFO pointers, level and native response
  always_comb begin
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    level_d   = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    s_ready_d = pop;
    s_rdata_d = pop ? mem[rptr_q] : s_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      error_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      s_ready_q   <= 1'b0;
      s_rdata_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      error_q     <= error_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      s_ready_q   <= s_ready_d;
      s_rdata_q   <= s_rdata_d;
    end
  end

  // Storage needs no reset: emptiness is carried by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= m_rdata;
  end

  assign error     = error_q;
  assign s_ready   = s_ready_q;
  assign s_rdata   = s_rdata_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;

endmodule
